torus_client_bp: RTL

- Endpoint client that attaches to the local port of one backpressured Hoplite torus switch.
- Injection side: buffers outgoing packets in a TX FIFO, presents the head packet on the switch input port, and holds it until the switch acks it.
- Ejection side: accepts packets delivered to this node into an RX FIFO and drives client backpressure from RX occupancy. It also keeps traffic counters and sticky error flags, and reports idle.

---
 rtl/torus_client_bp_pkg.sv | 26 ++
 rtl/torus_client_bp_sync_fifo.sv | 56 +++++
 rtl/torus_client_bp.sv | 131 +++++++++++++
 3 files changed

// File: rtl/torus_client_bp_pkg.sv
// Shared types for the torus endpoint client: message layout used on switch ports and in FIFOs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package torus_client_bp_pkg;

  localparam int PKG_X_W = 2;
  localparam int PKG_Y_W = 2;
  localparam int PKG_D_W = 32;
  localparam int MSG_W   = PKG_X_W + PKG_Y_W + PKG_D_W;

  // One packet as it travels through the switch local port and the client FIFOs.
  typedef struct packed {
    logic [PKG_X_W-1:0] x;
    logic [PKG_Y_W-1:0] y;
    logic [PKG_D_W-1:0] data;
  } torus_msg_t;

  // Destination compare used by the ejection-side address check.
  function automatic logic addr_mismatch(input logic [PKG_X_W-1:0] ox,
                                         input logic [PKG_Y_W-1:0] oy,
                                         input logic [PKG_X_W-1:0] my_x,
                                         input logic [PKG_Y_W-1:0] my_y);
    return (ox != my_x) || (oy != my_y);
  endfunction

endpackage

// File: rtl/torus_client_bp_sync_fifo.sv
// Generic synchronous FIFO with extra-bit pointers to tell full from empty.
// Latency: write visible at dout one cycle after push when empty (no bypass).
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
  parameter int D_W   = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [D_W-1:0]           din,
  input  logic                     pop,
  output logic [D_W-1:0]           dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [D_W-1:0] mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer computation; illegal push/pop are masked here so callers may be sloppy.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/torus_client_bp.sv
// Hoplite torus endpoint client: TX FIFO feeding the switch inject port, RX FIFO draining the eject port.
// Latency: tx push -> i_v one cycle later; o_v accept -> rx_v one cycle later.
// Backpressure: tx_rdy from TX fullness; client_b from registered RX fullness (drops + rx_ovf if ignored).
module torus_client_bp
  import torus_client_bp_pkg::*;
#(
  parameter int X_W      = PKG_X_W,
  parameter int Y_W      = PKG_Y_W,
  parameter int D_W      = PKG_D_W,
  parameter int VC_W     = 1,
  parameter int X        = 0,
  parameter int Y        = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_v,
  input  logic [X_W-1:0]   tx_x,
  input  logic [Y_W-1:0]   tx_y,
  input  logic [D_W-1:0]   tx_data,
  output logic             tx_rdy,
  output logic             i_v,
  output logic [X_W-1:0]   i_x,
  output logic [Y_W-1:0]   i_y,
  output logic [D_W-1:0]   i_data,
  input  logic             i_ack,
  input  logic             o_v,
  input  logic [X_W-1:0]   o_x,
  input  logic [Y_W-1:0]   o_y,
  input  logic [D_W-1:0]   o_data,
  output logic [VC_W-1:0]  client_b,
  output logic             rx_v,
  output logic [X_W-1:0]   rx_x,
  output logic [Y_W-1:0]   rx_y,
  output logic [D_W-1:0]   rx_data,
  input  logic             rx_rdy,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] recv_cnt,
  output logic             misroute,
  output logic             rx_ovf,
  output logic             done
);

  torus_msg_t tx_in, tx_head, rx_in, rx_head;
  logic       tx_full, tx_empty, tx_push, tx_pop;
  logic       rx_full, rx_empty, rx_accept, rx_pop;
  logic [$clog2(TX_DEPTH):0] tx_count_unused;
  logic [$clog2(RX_DEPTH):0] rx_count_unused;

  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
  logic             misroute_q, misroute_d;
  logic             rx_ovf_q, rx_ovf_d;

  // Injection side: head of TX FIFO sits on the switch port until acked.
  assign tx_in   = '{x: tx_x, y: tx_y, data: tx_data};
  assign tx_rdy  = ~tx_full;
  assign tx_push = tx_v & tx_rdy;
  assign i_v     = ~tx_empty;
  assign tx_pop  = i_v & i_ack;
  assign i_x     = tx_head.x;
  assign i_y     = tx_head.y;
  assign i_data  = tx_head.data;

  // Ejection side: client_b is a pure function of registered fullness, never of o_v.
  assign rx_in     = '{x: o_x, y: o_y, data: o_data};
  assign client_b  = {VC_W{rx_full}};
  assign rx_accept = o_v & ~rx_full;
  assign rx_v      = ~rx_empty;
  assign rx_pop    = rx_v & rx_rdy;
  assign rx_x      = rx_head.x;
  assign rx_y      = rx_head.y;
  assign rx_data   = rx_head.data;

  assign sent_cnt = sent_cnt_q;
  assign recv_cnt = recv_cnt_q;
  assign misroute = misroute_q;
  assign rx_ovf   = rx_ovf_q;
  assign done     = tx_empty & rx_empty & ~tx_v & ~o_v;

  sync_fifo #(.D_W(MSG_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (tx_in),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_unused)
  );

  sync_fifo #(.D_W(MSG_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_accept),
    .din   (rx_in),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count_unused)
  );

  // Next-state for traffic counters (wrapping) and sticky error flags.
  always_comb begin
    sent_cnt_d = sent_cnt_q + {{(CNT_W-1){1'b0}}, tx_pop};
    recv_cnt_d = recv_cnt_q + {{(CNT_W-1){1'b0}}, rx_accept};
    misroute_d = misroute_q |
                 (rx_accept & addr_mismatch(o_x, o_y, X_W'(X), Y_W'(Y)));
    rx_ovf_d   = rx_ovf_q | (o_v & rx_full);
  end

  // Status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt_q <= '0;
      recv_cnt_q <= '0;
      misroute_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      recv_cnt_q <= recv_cnt_d;
      misroute_q <= misroute_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

endmodule
